// File: rtl/on_the_fly_converter_pkg.sv
// Shared types and constants for the on-the-fly signed-digit converter.
// Optional digit-code checking is enabled with OTF_DIGIT_CHECK_EN.
package online_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } otf_state_t;

  localparam int unsigned DIGITS_DEFAULT = 9;

  // Digit codes as {plus, minus}; the unused code 2'b11 is read as zero.
  localparam logic [1:0] POS  = 2'b10;
  localparam logic [1:0] ZERO = 2'b00;
  localparam logic [1:0] NEG  = 2'b01;

endpackage

// File: rtl/on_the_fly_converter_if.sv
// Digit-in / result-out bundle of the on-the-fly converter.
// digit_err exists only when OTF_DIGIT_CHECK_EN is defined.
interface on_the_fly_converter_if
  import online_pkg::*;
#(
  parameter int unsigned W = DIGITS_DEFAULT + 1
);

  logic         start;
  logic         digit_valid;
  logic         digit_plus;
  logic         digit_minus;
  logic         digit_ready;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
`ifdef OTF_DIGIT_CHECK_EN
  logic         digit_err;

  modport master (
    output start, digit_valid, digit_plus, digit_minus,
    input  digit_ready, result, result_valid, busy, digit_err
  );
  modport slave (
    input  start, digit_valid, digit_plus, digit_minus,
    output digit_ready, result, result_valid, busy, digit_err
  );
`else
  modport master (
    output start, digit_valid, digit_plus, digit_minus,
    input  digit_ready, result, result_valid, busy
  );
  modport slave (
    input  start, digit_valid, digit_plus, digit_minus,
    output digit_ready, result, result_valid, busy
  );
`endif

endinterface

// File: rtl/on_the_fly_converter_step.sv
// One conversion step: next Q/QM from the current pair and one digit,
// using only shifts and selects (no carry propagation).
module otf_step
  import online_pkg::*;
#(
  parameter int unsigned W = DIGITS_DEFAULT + 1
) (
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_qm,
  input  logic [1:0]   i_digit,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_qm
);

  // Casting the W+1-bit concatenation to W bits drops the old MSB.
  always_comb begin
    o_q  = W'({i_q, 1'b0});
    o_qm = W'({i_qm, 1'b1});
    case (i_digit)
      POS: begin
        o_q  = W'({i_q, 1'b1});
        o_qm = W'({i_q, 1'b0});
      end
      NEG: begin
        o_q  = W'({i_qm, 1'b1});
        o_qm = W'({i_qm, 1'b0});
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/on_the_fly_converter.sv
// MSD-first borrow-save digit string to two's-complement converter.
// Define OTF_DIGIT_CHECK_EN to flag the illegal plus=minus=1 digit code.
module on_the_fly_converter
  import online_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEFAULT,
  parameter int unsigned W      = DIGITS + 1
) (
  input logic                  clk,
  input logic                  rst_n,
  on_the_fly_converter_if.slave bus
);

  localparam int unsigned   CW   = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  otf_state_t    r_state;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_qm;
  logic [W-1:0]  r_result;
  logic [CW-1:0] r_cnt;
  logic          r_result_valid;
  logic          r_busy;

  logic          w_ready;
  logic          w_accept;
  logic          w_last;
  logic [W-1:0]  w_q_base;
  logic [W-1:0]  w_qm_base;
  logic [W-1:0]  w_q_next;
  logic [W-1:0]  w_qm_next;
  logic [CW-1:0] w_cnt_base;

  // A start restarts from the cleared pair so the same-cycle digit is the MSD.
  assign w_ready    = rst_n & (bus.start | (r_state == CONV));
  assign w_accept   = w_ready & bus.digit_valid;
  assign w_q_base   = bus.start ? '0 : r_q;
  assign w_qm_base  = bus.start ? '1 : r_qm;
  assign w_cnt_base = bus.start ? '0 : r_cnt;
  assign w_last     = (w_cnt_base == LAST);

  otf_step #(.W(W)) u_step (
    .i_q     (w_q_base),
    .i_qm    (w_qm_base),
    .i_digit ({bus.digit_plus, bus.digit_minus}),
    .o_q     (w_q_next),
    .o_qm    (w_qm_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_q            <= '0;
      r_qm           <= '1;
      r_cnt          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      if (bus.start) begin
        r_state        <= CONV;
        r_q            <= '0;
        r_qm           <= '1;
        r_cnt          <= '0;
        r_result       <= '0;
        r_result_valid <= 1'b0;
        r_busy         <= 1'b1;
      end
      // Later assignments refine the restart when a digit is taken too.
      if (w_accept) begin
        r_q   <= w_q_next;
        r_qm  <= w_qm_next;
        r_cnt <= w_cnt_base + CW'(1);
        if (w_last) begin
          r_state        <= DONE;
          r_result       <= w_q_next;
          r_result_valid <= 1'b1;
          r_busy         <= 1'b0;
        end
      end
    end
  end

  assign bus.digit_ready  = w_ready;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = r_busy;

`ifdef OTF_DIGIT_CHECK_EN
  logic r_digit_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digit_err <= 1'b0;
    end else begin
      if (bus.start) r_digit_err <= 1'b0;
      if (w_accept && bus.digit_plus && bus.digit_minus) r_digit_err <= 1'b1;
    end
  end

  assign bus.digit_err = r_digit_err;
`endif

endmodule

// File: tb/tb_on_the_fly_converter.sv
// Bench for on_the_fly_converter: fixed vectors, hand-written corner
// sequences and random digit strings against an arithmetic model.
module tb_on_the_fly_converter;
  import online_pkg::*;

  localparam int unsigned DIGITS = 9;
  localparam int unsigned W      = DIGITS + 1;
  localparam int          NONE   = 15;

  typedef struct packed {
    logic [17:0]  codes;
    logic [3:0]   gap_at;
    logic [3:0]   gap_len;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  on_the_fly_converter_if #(.W(W)) u_if ();

  on_the_fly_converter #(.DIGITS(DIGITS), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [1:0] c);
    u_if.start       = s;
    u_if.digit_valid = v;
    u_if.digit_plus  = c[1];
    u_if.digit_minus = c[0];
  endtask

  function automatic logic [1:0] enc(input int d);
    case (d)
      1:       return POS;
      -1:      return NEG;
      2:       return 2'b11;
      default: return ZERO;
    endcase
  endfunction

  function automatic logic [17:0] mk(input int d0, input int d1, input int d2,
                                     input int d3, input int d4, input int d5,
                                     input int d6, input int d7, input int d8);
    return {enc(d8), enc(d7), enc(d6), enc(d5), enc(d4), enc(d3), enc(d2), enc(d1), enc(d0)};
  endfunction

  // Value of the string: Horner evaluation of sum d_i * 2^(8-i), wrapped to W bits.
  function automatic logic [W-1:0] model_val(input logic [17:0] c);
    int v = 0;
    for (int i = 0; i < 9; i++) v = 2 * v + (int'(c[2*i+1]) - int'(c[2*i]));
    return W'(v);
  endfunction

  function automatic logic model_err(input logic [17:0] c);
    logic e = 1'b0;
    for (int i = 0; i < 9; i++) e |= (c[2*i+1] & c[2*i]);
    return e;
  endfunction

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_conv(input logic [17:0] codes, input int gap_at, input int gap_len,
                          input logic [W-1:0] exp, input string tag);
    for (int i = 0; i < 9; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          drive(1'b0, 1'b0, ZERO);
          @(negedge clk);
          check({tag, " gap busy"}, 32'(u_if.busy), 32'd1);
          check({tag, " gap valid"}, 32'(u_if.result_valid), 32'd0);
          cyc();
        end
      end
      drive(i == 0, 1'b1, codes[2*i +: 2]);
      @(negedge clk);
      check({tag, " ready"}, 32'(u_if.digit_ready), 32'd1);
      if (i > 0) begin
        check({tag, " busy"}, 32'(u_if.busy), 32'd1);
        check({tag, " early valid"}, 32'(u_if.result_valid), 32'd0);
      end
      cyc();
    end
    drive(1'b0, 1'b0, ZERO);
    @(negedge clk);
    check({tag, " result"}, 32'(u_if.result), 32'(exp));
    check({tag, " valid"}, 32'(u_if.result_valid), 32'd1);
    check({tag, " busy end"}, 32'(u_if.busy), 32'd0);
`ifdef OTF_DIGIT_CHECK_EN
    check({tag, " digit_err"}, 32'(u_if.digit_err), 32'(model_err(codes)));
`endif
    cyc();
  endtask

  initial begin
    vecs[0] = '{mk( 1, 1, 1, 1, 1, 1, 1, 1, 1), 4'(NONE), 4'd0, 10'd511};
    vecs[1] = '{mk(-1,-1,-1,-1,-1,-1,-1,-1,-1), 4'(NONE), 4'd0, 10'h201};
    vecs[2] = '{mk( 1,-1, 0, 0, 0, 0, 0, 0, 0), 4'(NONE), 4'd0, 10'd128};
    vecs[3] = '{mk( 0, 0, 0, 0, 0, 0, 0, 0,-1), 4'(NONE), 4'd0, 10'h3FF};
    vecs[4] = '{mk( 1, 1, 1, 1, 1, 1, 1, 1, 1), 4'd4,     4'd3, 10'd511};
    vecs[5] = '{mk( 1, 0,-1, 0, 0, 0, 0, 0, 1), 4'd2,     4'd1, 10'd193};

    drive(1'b0, 1'b0, ZERO);
    rst_n = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    check("reset result", 32'(u_if.result), 32'd0);
    check("reset valid", 32'(u_if.result_valid), 32'd0);
    check("reset busy", 32'(u_if.busy), 32'd0);
    check("reset ready", 32'(u_if.digit_ready), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Digits without start in IDLE are not taken.
    drive(1'b0, 1'b1, POS);
    @(negedge clk);
    check("idle ready", 32'(u_if.digit_ready), 32'd0);
    cyc();
    @(negedge clk);
    check("idle busy", 32'(u_if.busy), 32'd0);
    cyc();

    for (int k = 0; k < 6; k++)
      run_conv(vecs[k].codes, int'(vecs[k].gap_at), int'(vecs[k].gap_len), vecs[k].exp,
               $sformatf("vec%0d", k));

    // DONE ignores digits without start and holds the result.
    drive(1'b0, 1'b1, POS);
    @(negedge clk);
    check("done ready", 32'(u_if.digit_ready), 32'd0);
    cyc();
    @(negedge clk);
    check("done hold result", 32'(u_if.result), 32'd193);
    check("done hold valid", 32'(u_if.result_valid), 32'd1);
    cyc();

    // Restart after five digits; only the second string completes.
    drive(1'b1, 1'b1, POS);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, POS);
      @(negedge clk);
      check("abort pre valid", 32'(u_if.result_valid), 32'd0);
      cyc();
    end
    run_conv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), NONE, 0, 10'd0, "abort");

    // Reset in the middle of a conversion, with start asserted.
    drive(1'b1, 1'b1, NEG);
    cyc();
    drive(1'b0, 1'b1, POS);
    cyc();
    cyc();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, POS);
    @(negedge clk);
    check("rst ready", 32'(u_if.digit_ready), 32'd0);
    cyc();
    @(negedge clk);
    check("rst result", 32'(u_if.result), 32'd0);
    check("rst valid", 32'(u_if.result_valid), 32'd0);
    check("rst busy", 32'(u_if.busy), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, ZERO);
    cyc();
    @(negedge clk);
    check("post rst busy", 32'(u_if.busy), 32'd0);
    check("post rst valid", 32'(u_if.result_valid), 32'd0);
    cyc();

`ifdef OTF_DIGIT_CHECK_EN
    run_conv(mk(0, 0, 0, 2, 0, 0, 0, 0, 0), NONE, 0, 10'd0, "err");
    @(negedge clk);
    check("err sticky", 32'(u_if.digit_err), 32'd1);
    cyc();
    run_conv(mk(1, 1, 1, 1, 1, 1, 1, 1, 1), NONE, 0, 10'd511, "err clear");
`endif

    for (int k = 0; k < 25; k++) begin
      logic [17:0] c;
      c = 18'($urandom);
      run_conv(c, int'($urandom_range(1, 9)), int'($urandom_range(0, 2)), model_val(c),
               $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
